// File: rtl/hsv_core_flush_sequencer_if.sv
// ---------------------------------------------------------------------------
// hsv_core_flush_sequencer_if
// Bundles the global flush handshake between the flush sequencer, the unit
// that requests flushes, and the pipeline stages that acknowledge them.
//
// Handshake: four-phase. The requester pulses flush_begin for one cycle with
// flush_target_i valid in that cycle. The sequencer raises flush_req with a
// stable flush_target; every enabled stage raises its flush_acks bit, the
// sequencer holds flush_req for a minimum time, drops it, waits for every
// enabled ack to drop, then pulses flush_done for one cycle.
//
// Signals:
//   flush_begin     requester -> sequencer  1-cycle flush request strobe
//   flush_target_i  requester -> sequencer  restart PC, sampled with strobe
//   flush_acks      stages    -> sequencer  per-stage acknowledge
//   flush_req       sequencer -> stages     broadcast flush request
//   flush_target    sequencer -> stages     broadcast restart target
//   flush_done      sequencer -> requester  1-cycle completion pulse
//   busy            sequencer -> requester  sequence active or queued
//   timeout_err     sequencer -> requester  sticky watchdog error
//   timeout_chans   sequencer -> requester  channels that missed a deadline
// Modports: master = sequencer side, slave = requester/stage side.
// ---------------------------------------------------------------------------
interface hsv_core_flush_sequencer_if #(
  parameter int NUM_ACKS = 9,
  parameter int WIDTH    = 32
);
  logic                flush_begin;
  logic [WIDTH-1:0]    flush_target_i;
  logic [NUM_ACKS-1:0] flush_acks;
  logic                flush_req;
  logic [WIDTH-1:0]    flush_target;
  logic                flush_done;
  logic                busy;
  logic                timeout_err;
  logic [NUM_ACKS-1:0] timeout_chans;

  modport master (
    input  flush_begin, flush_target_i, flush_acks,
    output flush_req, flush_target, flush_done, busy, timeout_err, timeout_chans
  );

  modport slave (
    output flush_begin, flush_target_i, flush_acks,
    input  flush_req, flush_target, flush_done, busy, timeout_err, timeout_chans
  );
endinterface

// File: rtl/hsv_core_flush_sequencer.sv
// ---------------------------------------------------------------------------
// hsv_core_flush_sequencer
// Global flush handshake sequencer for the hsv_core pipeline. Takes flush
// requests, broadcasts flush_req/flush_target to NUM_ACKS stages, waits for
// all enabled acks to rise, holds the request HOLD_CYCLES, drops it, waits
// for all enabled acks to fall, then pulses flush_done. One further request
// arriving while busy is queued in a 1-deep pending slot (last one wins).
//
// Ports:
//   clk_core    in   core clock
//   rst_core_n  in   asynchronous reset, active low
//   fif         master modport of hsv_core_flush_sequencer_if
//   state_dbg   out  current FSM state (0 IDLE, 1 RAISE, 2 HOLD, 3 FALL)
//
// Optional feature: define HSV_FLUSH_TIMEOUT_EN to enable a watchdog that
// forces progress out of RAISE/FALL after TIMEOUT_CYCLES and records the
// offending channels. Without it timeout_err/timeout_chans are tied to 0.
// ---------------------------------------------------------------------------
module hsv_core_flush_sequencer #(
  parameter int                  NUM_ACKS       = 9,
  parameter int                  WIDTH          = 32,
  parameter logic [NUM_ACKS-1:0] ACK_MASK       = '1,
  parameter int                  HOLD_CYCLES    = 1,
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  hsv_core_flush_sequencer_if.master   fif,
  output logic [1:0]                   state_dbg
);

  if (NUM_ACKS < 1) begin : g_bad_num_acks
    $error("NUM_ACKS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    HOLD  = 2'd2,
    FALL  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q;
  logic             pending_q;
  logic [WIDTH-1:0] pending_target_q;
  logic [WIDTH-1:0] flush_target_q;
  logic             flush_req_q;
  logic             flush_done_q;

  logic rise_ok, fall_ok;
  logic tmo_rise, tmo_fall;
  logic raise_exit, fall_exit;
  logic load_from_in, load_from_pend;

  // Masked-off channels read as "already at the required level".
  assign rise_ok = &(fif.flush_acks | ~ACK_MASK);
  assign fall_ok = ~|(fif.flush_acks & ACK_MASK);

  always_comb begin
    state_d        = state_q;
    raise_exit     = 1'b0;
    fall_exit      = 1'b0;
    load_from_in   = 1'b0;
    load_from_pend = 1'b0;
    case (state_q)
      IDLE: begin
        if (fif.flush_begin) begin
          state_d      = RAISE;
          load_from_in = 1'b1;
        end
      end
      RAISE: begin
        if (rise_ok || tmo_rise) begin
          state_d    = HOLD;
          raise_exit = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = FALL;
      end
      FALL: begin
        if (fall_ok || tmo_fall) begin
          fall_exit = 1'b1;
          // A strobe in the exiting cycle is newer than anything pending.
          if (fif.flush_begin) begin
            state_d      = RAISE;
            load_from_in = 1'b1;
          end else if (pending_q) begin
            state_d        = RAISE;
            load_from_pend = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q          <= IDLE;
      hold_cnt_q       <= '0;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
      flush_target_q   <= '0;
      flush_req_q      <= 1'b0;
      flush_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_req_q  <= (state_d == RAISE) || (state_d == HOLD);
      flush_done_q <= fall_exit;

      if (load_from_in)        flush_target_q <= fif.flush_target_i;
      else if (load_from_pend) flush_target_q <= pending_target_q;

      // Counter loads HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES cycles.
      if (raise_exit)                                hold_cnt_q <= HW'(HOLD_CYCLES - 1);
      else if (state_q == HOLD && hold_cnt_q != '0)  hold_cnt_q <= hold_cnt_q - 1'b1;

      if (fall_exit) begin
        pending_q <= 1'b0;
      end else if (fif.flush_begin && state_q != IDLE) begin
        pending_q        <= 1'b1;
        pending_target_q <= fif.flush_target_i;
      end
    end
  end

`ifdef HSV_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]       tmo_cnt_q;
  logic                tmo_hit;
  logic                tmo_err_q;
  logic [NUM_ACKS-1:0] tmo_chans_q;

  assign tmo_hit  = ((state_q == RAISE) || (state_q == FALL)) &&
                    (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_rise = tmo_hit && (state_q == RAISE) && !rise_ok;
  assign tmo_fall = tmo_hit && (state_q == FALL)  && !fall_ok;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
      tmo_chans_q <= '0;
    end else begin
      // Any state change restarts the count, so each RAISE/FALL visit is timed alone.
      if (state_d != state_q)                         tmo_cnt_q <= '0;
      else if (state_q == RAISE || state_q == FALL)   tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (tmo_rise) begin
        tmo_err_q   <= 1'b1;
        tmo_chans_q <= tmo_chans_q | (~fif.flush_acks & ACK_MASK);
      end else if (tmo_fall) begin
        tmo_err_q   <= 1'b1;
        tmo_chans_q <= tmo_chans_q | (fif.flush_acks & ACK_MASK);
      end
    end
  end

  assign fif.timeout_err   = tmo_err_q;
  assign fif.timeout_chans = tmo_chans_q;
`else
  assign tmo_rise          = 1'b0;
  assign tmo_fall          = 1'b0;
  assign fif.timeout_err   = 1'b0;
  assign fif.timeout_chans = '0;
`endif

  assign fif.flush_req    = flush_req_q;
  assign fif.flush_target = flush_target_q;
  assign fif.flush_done   = flush_done_q;
  assign fif.busy         = (state_q != IDLE) || pending_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_hsv_core_flush_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hsv_core_flush_sequencer
// Two sequencer instances: A (all channels enabled, HOLD_CYCLES=1) with acks
// driven by hand, and B (channel 0 masked, HOLD_CYCLES=4) with a stage model
// that mirrors flush_req onto channels 8..1 and drives channel 0 inverted.
// Each completed sequence is described by {req_high_cycles[15:0], target}.
// ---------------------------------------------------------------------------
module tb_hsv_core_flush_sequencer;
  localparam int NA = 9;
  localparam int WD = 32;
  localparam int W  = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsv_core_flush_sequencer_if #(.NUM_ACKS(NA), .WIDTH(WD)) ifa ();
  hsv_core_flush_sequencer_if #(.NUM_ACKS(NA), .WIDTH(WD)) ifb ();
  logic [1:0] dbg_a, dbg_b;

  hsv_core_flush_sequencer #(
    .NUM_ACKS(NA), .WIDTH(WD), .ACK_MASK(9'h1FF), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(16)
  ) u_a (
    .clk_core(clk), .rst_core_n(rst_n), .fif(ifa), .state_dbg(dbg_a)
  );

  hsv_core_flush_sequencer #(
    .NUM_ACKS(NA), .WIDTH(WD), .ACK_MASK(9'h1FE), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) u_b (
    .clk_core(clk), .rst_core_n(rst_n), .fif(ifb), .state_dbg(dbg_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic strobe_a(input logic [WD-1:0] tgt);
    @(posedge clk); #1;
    ifa.flush_begin = 1'b1; ifa.flush_target_i = tgt;
    @(posedge clk); #1;
    ifa.flush_begin = 1'b0; ifa.flush_target_i = 32'hDEAD_BEEF;
  endtask

  task automatic strobe_b(input logic [WD-1:0] tgt);
    @(posedge clk); #1;
    ifb.flush_begin = 1'b1; ifb.flush_target_i = tgt;
    @(posedge clk); #1;
    ifb.flush_begin = 1'b0; ifb.flush_target_i = 32'hDEAD_BEEF;
  endtask

  task automatic wait_idle(input bit inst, input int budget);
    int n;
    logic b;
    n = 0;
    @(negedge clk);
    b = inst ? ifb.busy : ifa.busy;
    while (b && n < budget) begin
      @(negedge clk);
      n++;
      b = inst ? ifb.busy : ifa.busy;
    end
    check(inst ? "b_idle_within_budget" : "a_idle_within_budget", b, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_req"},    ifa.flush_req, 1'b0);
    check({tag, "_a_target"}, ifa.flush_target, '0);
    check({tag, "_a_done"},   ifa.flush_done, 1'b0);
    check({tag, "_a_busy"},   ifa.busy, 1'b0);
    check({tag, "_a_terr"},   ifa.timeout_err, 1'b0);
    check({tag, "_a_tchans"}, ifa.timeout_chans, '0);
    check({tag, "_a_state"},  dbg_a, 2'd0);
    check({tag, "_b_req"},    ifb.flush_req, 1'b0);
    check({tag, "_b_target"}, ifb.flush_target, '0);
    check({tag, "_b_done"},   ifb.flush_done, 1'b0);
    check({tag, "_b_busy"},   ifb.busy, 1'b0);
    check({tag, "_b_terr"},   ifb.timeout_err, 1'b0);
    check({tag, "_b_tchans"}, ifb.timeout_chans, '0);
    check({tag, "_b_state"},  dbg_b, 2'd0);
  endtask

  // Stage model for B: enabled channels follow flush_req one cycle late,
  // masked channel 0 is driven opposite to show it is ignored both ways.
  initial begin
    ifb.flush_acks = 9'h001;
    forever begin
      @(posedge clk); #1;
      ifb.flush_acks = ifb.flush_req ? 9'h1FE : 9'h001;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_req[2];
    logic        prev_done[2];
    logic        stable[2];
    int          len[2];
    logic [WD-1:0] cap[2];
    logic        r, d, have;
    logic [WD-1:0] t;
    logic [W-1:0]  e;
    for (int i = 0; i < 2; i++) begin
      prev_req[i] = 1'b0; prev_done[i] = 1'b0; stable[i] = 1'b1; len[i] = 0; cap[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        r = (i == 0) ? ifa.flush_req    : ifb.flush_req;
        d = (i == 0) ? ifa.flush_done   : ifb.flush_done;
        t = (i == 0) ? ifa.flush_target : ifb.flush_target;
        if (!rst_n) begin
          prev_req[i] = 1'b0; prev_done[i] = 1'b0; len[i] = 0;
        end else begin
          // Completion of the previous sequence is handled before a new rise
          // in the same cycle overwrites the captured target.
          if (d) begin
            check($sformatf("i%0d_done_single_cycle", i), prev_done[i], 1'b0);
            have = (i == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
            check($sformatf("i%0d_done_expected", i), have, 1'b1);
            if (have) begin
              e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
              check($sformatf("i%0d_done_target", i), cap[i], e[WD-1:0]);
              check($sformatf("i%0d_req_high_cycles", i), len[i], e[W-1:WD]);
              check($sformatf("i%0d_target_stable", i), stable[i], 1'b1);
            end
          end
          if (r && !prev_req[i]) begin
            cap[i] = t; len[i] = 1; stable[i] = 1'b1;
          end else if (r) begin
            len[i]++;
            if (t !== cap[i]) stable[i] = 1'b0;
          end
          prev_req[i]  = r;
          prev_done[i] = d;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    ifa.flush_begin = 1'b0; ifa.flush_target_i = '0; ifa.flush_acks = '0;
    ifb.flush_begin = 1'b0; ifb.flush_target_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A: acks rise on the 4th edge of RAISE, HOLD=1 -> req high 5 cycles.
    exp_a.push_back({16'd5, 32'h8000_0100});
    strobe_a(32'h8000_0100);
    repeat (3) @(posedge clk); #1;
    ifa.flush_acks = '1;
    repeat (4) @(posedge clk); #1;
    ifa.flush_acks = '0;
    wait_idle(1'b0, 50);

    // A: acks held high in IDLE do not start anything.
    ifa.flush_acks = '1;
    repeat (3) @(negedge clk);
    check("a_idle_acks_state", dbg_a, 2'd0);
    check("a_idle_acks_req", ifa.flush_req, 1'b0);

    // A: strobe landing on the exiting FALL cycle starts the next sequence.
    exp_a.push_back({16'd2, 32'h0000_0600});
    exp_a.push_back({16'd2, 32'h0000_0700});
    strobe_a(32'h0000_0600);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.flush_acks = '0; ifa.flush_begin = 1'b1; ifa.flush_target_i = 32'h0000_0700;
    @(posedge clk); #1;
    ifa.flush_begin = 1'b0; ifa.flush_target_i = 32'hDEAD_BEEF; ifa.flush_acks = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.flush_acks = '0;
    wait_idle(1'b0, 50);

    // B: masked ack[0] ignored, HOLD=4 -> req high 1+4; two strobes in HOLD,
    // the last one is serviced straight after FALL.
    exp_b.push_back({16'd5, 32'h0000_0300});
    strobe_b(32'h0000_0300);
    strobe_b(32'h0000_0100);
    strobe_b(32'h0000_0200);
    exp_b.push_back({16'd5, 32'h0000_0200});
    n = 0;
    @(negedge clk);
    while (ifb.flush_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_fall_state", dbg_b, 2'd3);
    check("b_fall_busy", ifb.busy, 1'b1);
    @(negedge clk);
    check("b_pending_state_raise", dbg_b, 2'd1);
    check("b_pending_target", ifb.flush_target, 32'h0000_0200);
    check("b_pending_busy", ifb.busy, 1'b1);
    wait_idle(1'b1, 60);

    // B: reset in HOLD with a request pending discards everything.
    strobe_b(32'h0000_0400);
    strobe_b(32'h0000_0500);
    @(negedge clk);
    check("b_hold_state", dbg_b, 2'd2);
    check("b_hold_busy", ifb.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("b_after_reset_req", ifb.flush_req, 1'b0);
    check("b_after_reset_busy", ifb.busy, 1'b0);
    check("b_after_reset_state", dbg_b, 2'd0);

`ifdef HSV_FLUSH_TIMEOUT_EN
    // A: ack[3] never rises -> forced to HOLD after 16 RAISE cycles.
    ifa.flush_acks = 9'h1F7;
    exp_a.push_back({16'd17, 32'h0000_0A00});
    strobe_a(32'h0000_0A00);
    repeat (17) @(posedge clk); #1;
    ifa.flush_acks = '0;
    wait_idle(1'b0, 60);
    check("a_timeout_err", ifa.timeout_err, 1'b1);
    check("a_timeout_chans", ifa.timeout_chans, 9'h008);
    repeat (5) @(negedge clk);
    check("a_timeout_err_sticky", ifa.timeout_err, 1'b1);
    check("a_timeout_chans_sticky", ifa.timeout_chans, 9'h008);
    check("b_timeout_err_clear", ifb.timeout_err, 1'b0);
`else
    check("a_timeout_err_tied", ifa.timeout_err, 1'b0);
    check("a_timeout_chans_tied", ifa.timeout_chans, '0);
    check("b_timeout_err_tied", ifb.timeout_err, 1'b0);
    check("b_timeout_chans_tied", ifb.timeout_chans, '0);
`endif

    repeat (3) @(negedge clk);
    check("a_exp_queue_drained", exp_a.size(), 0);
    check("b_exp_queue_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule
